// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax row controller.
// Holds the controller state encoding and the fp16 ordering key.
package softmax_pkg;

  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PASS1 = 3'd2,
    WAIT  = 3'd3,
    PASS2 = 3'd4
  } state_e;

  // Maps fp16 to an unsigned key whose ordering matches numeric order, with -0 below +0.
  function automatic logic [15:0] fp16_key(input logic [15:0] x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

endpackage

// File: rtl/softmax_row_ctrl_rd_skid2.sv
// Two-entry skid FIFO behind a line buffer read port with one cycle of latency.
// Counting the read in flight as a used credit means a stall can never overrun the FIFO.
module rd_skid2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue,
  input  logic        issue_last,
  input  logic [15:0] rdata,
  input  logic        pop_req,
  output logic        can_issue,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last
);
  logic        inflight_q, inflight_d;
  logic        inflight_last_q, inflight_last_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  occ_q, occ_d;
  logic [2:0]  credit_use;
  logic        push, pop;
  logic [16:0] ent0, ent1, head_ent;

  assign push       = inflight_q;
  assign out_valid  = (occ_q != 2'd0);
  assign pop        = pop_req & out_valid;
  assign credit_use = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign can_issue  = (credit_use < 3'd2);

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_ent
    logic [16:0] ent_q, ent_d;

    always_comb begin
      ent_d = ent_q;
      if (push && (tail_q == 1'(gi))) ent_d = {inflight_last_q, rdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ent_q <= '0;
      else        ent_q <= ent_d;
    end
  end

  assign ent0     = g_ent[0].ent_q;
  assign ent1     = g_ent[1].ent_q;
  assign head_ent = head_q ? ent1 : ent0;
  assign out_data = head_ent[15:0];
  assign out_last = out_valid & head_ent[16];

  always_comb begin
    inflight_d      = issue;
    inflight_last_d = issue & issue_last;
    tail_d          = tail_q ^ push;
    head_d          = head_q ^ pop;
    occ_d           = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      head_q          <= 1'b0;
      tail_q          <= 1'b0;
      occ_q           <= 2'd0;
    end else begin
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      occ_q           <= occ_d;
    end
  end

endmodule

// File: rtl/softmax_row_ctrl.sv
// Softmax row sequencer: loads one fp16 row into the line buffer while tracking its max,
// then replays it once for exp/sum and once for normalize through a credit-controlled skid.
module softmax_row_ctrl
  import softmax_pkg::*;
#(
  parameter int C_MAX  = 1024,
  parameter int ADDR_W = $clog2(C_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              lb_we,
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [15:0]       lb_wdata,
  output logic [ADDR_W-1:0] lb_raddr,
  input  logic [15:0]       lb_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic              out_pass,
  output logic              out_last,
  output logic [15:0]       row_max,
  input  logic              pass2_go,
  output logic              busy,
  output logic              done
);
  localparam int LW = ADDR_W + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(C_MAX);
  localparam logic [LW-1:0] ONE     = LW'(1);

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] wr_cnt_q, wr_cnt_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   row_max_q, row_max_d;
  logic          done_q, done_d;
  logic [LW-1:0] cfg_len_eff;
  logic          accept, replay, rd_issue, rd_last, can_issue, pop;

  assign cfg_len_eff = ((cfg_len == '0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;

  assign in_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept   = in_valid & in_ready;
  assign lb_we    = accept;
  assign lb_wdata = accept ? in_data : 16'h0000;
  assign lb_waddr = wr_cnt_q[ADDR_W-1:0];
  assign lb_raddr = rd_ptr_q[ADDR_W-1:0];

  assign replay   = (state_q == PASS1) || (state_q == PASS2);
  assign rd_issue = replay && (rd_ptr_q < len_q) && can_issue;
  assign rd_last  = (rd_ptr_q == (len_q - ONE));
  assign pop      = out_valid & out_ready;

  assign out_pass = (state_q == PASS2);
  assign row_max  = row_max_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  rd_skid2 u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (rd_issue),
    .issue_last (rd_last),
    .rdata      (lb_rdata),
    .pop_req    (out_ready),
    .can_issue  (can_issue),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_cnt_d  = wr_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    row_max_d = row_max_q;
    done_d    = 1'b0;
    if (rd_issue) rd_ptr_d = rd_ptr_q + ONE;

    case (state_q)
      IDLE: begin
        if (accept) begin
          len_d     = cfg_len_eff;
          row_max_d = in_data;
          rd_ptr_d  = '0;
          if (cfg_len_eff == ONE) begin
            state_d  = PASS1;
            wr_cnt_d = '0;
          end else begin
            state_d  = LOAD;
            wr_cnt_d = ONE;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          if (fp16_key(in_data) > fp16_key(row_max_q)) row_max_d = in_data;
          if (wr_cnt_q == (len_q - ONE)) begin
            state_d  = PASS1;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + ONE;
          end
        end
      end
      PASS1: begin
        if (pop && out_last) state_d = WAIT;
      end
      WAIT: begin
        rd_ptr_d = '0;
        if (pass2_go) state_d = PASS2;
      end
      PASS2: begin
        // Pointer parks at zero so the idle read address matches the reset value.
        if (pop && out_last) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          rd_ptr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= LEN_MAX;
      wr_cnt_q  <= '0;
      rd_ptr_q  <= '0;
      row_max_q <= FP16_NEG_INF;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      row_max_q <= row_max_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_softmax_row_ctrl.sv
// Self-checking bench for softmax_row_ctrl: line buffer model, beat monitor and scoreboard.
`timescale 1ns/1ps
module tb_softmax_row_ctrl;
  import softmax_pkg::*;

  localparam int C_MAX  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W:0]   cfg_len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_data = '0;
  logic              lb_we;
  logic [ADDR_W-1:0] lb_waddr;
  logic [15:0]       lb_wdata;
  logic [ADDR_W-1:0] lb_raddr;
  logic [15:0]       lb_rdata = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [15:0]       out_data;
  logic              out_pass;
  logic              out_last;
  logic [15:0]       row_max;
  logic              pass2_go = 1'b1;
  logic              busy;
  logic              done;

  softmax_row_ctrl #(.C_MAX(C_MAX), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
    .lb_raddr(lb_raddr), .lb_rdata(lb_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pass(out_pass), .out_last(out_last), .row_max(row_max),
    .pass2_go(pass2_go), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] lb_mem [C_MAX];
  always @(posedge clk) begin
    if (lb_we) lb_mem[lb_waddr] <= lb_wdata;
    lb_rdata <= lb_mem[lb_raddr];
  end

  // Monitor: records accepted beats and writes, counts done pulses and stall violations.
  logic [17:0] obs_q [$];
  logic [25:0] wr_q [$];
  int          done_cnt = 0;
  int          stall_viol = 0;
  int          occ_viol = 0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_beat = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) obs_q.push_back({out_pass, out_last, out_data});
      if (lb_we) wr_q.push_back({lb_waddr, lb_wdata});
      if (done) done_cnt <= done_cnt + 1;
      if (prev_stall && (!out_valid || ({out_pass, out_last, out_data} !== prev_beat)))
        stall_viol <= stall_viol + 1;
      if (dut.u_skid.occ_q > 2'd2) occ_viol <= occ_viol + 1;
      prev_stall <= out_valid && !out_ready;
      prev_beat  <= {out_pass, out_last, out_data};
    end else begin
      prev_stall <= 1'b0;
    end
  end

  int          errors = 0;
  int          checks = 0;
  int          obs_rd = 0;
  logic [17:0] exp_q [$];
  logic [15:0] row_vals [C_MAX];
  logic [15:0] exp_max;

  function automatic bit fp16_gt(input logic [15:0] a, input logic [15:0] b);
    if (a[15] != b[15]) return b[15];
    if (!a[15]) return a[14:0] > b[14:0];
    return a[14:0] < b[14:0];
  endfunction

  // Drives one row and pushes both replay passes into the scoreboard.
  task automatic drive_row(input logic [ADDR_W:0] cfg, input int n);
    int len;
    len = ((cfg == '0) || (cfg > 11'd1024)) ? C_MAX : int'(cfg);
    exp_max = row_vals[0];
    for (int i = 1; i < n; i++) if (fp16_gt(row_vals[i], exp_max)) exp_max = row_vals[i];
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < len; i++) exp_q.push_back({p[0], (i == len - 1), row_vals[i]});
    cfg_len = cfg;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = row_vals[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, done, lb_we, out_pass, out_last} !== 7'b1000000) begin
      errors++; $display("FAIL reset_flags got=%b expected=%b", {in_ready, out_valid, busy, done, lb_we, out_pass, out_last}, 7'b1000000);
    end
    checks++;
    if (row_max !== 16'hFC00) begin errors++; $display("FAIL reset_row_max got=%h expected=fc00", row_max); end
    checks++;
    if ({lb_waddr, lb_raddr, lb_wdata} !== 36'd0) begin
      errors++; $display("FAIL reset_addr got=%h/%h/%h expected=0/0/0", lb_waddr, lb_raddr, lb_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b1000 || row_max !== 16'hFC00) begin
      errors++; $display("FAIL idle_after_reset got=%b/%h expected=1000/fc00", {in_ready, out_valid, busy, done}, row_max);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int wbase, dbase, cyc;
    logic [17:0] e;
    row_vals[0] = 16'h3C00; row_vals[1] = 16'hC000; row_vals[2] = 16'h4200; row_vals[3] = 16'h0000;
    out_ready = 1'b1; pass2_go = 1'b1;
    wbase = wr_q.size(); dbase = done_cnt;
    drive_row(11'd4, 4);
    @(negedge clk);
    checks++;
    if (row_max !== 16'h4200) begin errors++; $display("FAIL basic_row_max got=%h expected=4200", row_max); end
    checks++;
    if (wr_q.size() - wbase != 4) begin errors++; $display("FAIL basic_write_count got=%0d expected=4", wr_q.size() - wbase); end
    for (int i = 0; i < 4 && wbase + i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[wbase + i] !== {10'(i), row_vals[i]}) begin
        errors++; $display("FAIL basic_write%0d got=%h expected=%h", i, wr_q[wbase + i], {10'(i), row_vals[i]});
      end
    end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < 200);
    checks++;
    if (!done) begin errors++; $display("FAIL basic_done got=timeout expected=pulse"); end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (done_cnt - dbase != 1) begin errors++; $display("FAIL basic_done_count got=%0d expected=1", done_cnt - dbase); end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle got=%b%b expected=10", in_ready, busy); end
    while (obs_rd < obs_q.size()) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL basic_extra_beat got=%h expected=none", obs_q[obs_rd]); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL basic_beat got=%h expected=%h", obs_q[obs_rd], e); end
      end
      obs_rd++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing got=%0d expected=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_backpressure();
    int cyc, dbase;
    logic [17:0] e;
    pass2_go = 1'b1;
    dbase = done_cnt;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) row_vals[i] = 16'($urandom_range(0, 16'hFFFF));
      drive_row(11'd8, 8);
      cyc = 0;
      do begin
        @(negedge clk); cyc++;
        if (!done) begin @(posedge clk); #1; out_ready = ($urandom_range(0, 1) == 1); end
      end while (!done && cyc < 500);
      checks++;
      if (!done) begin errors++; $display("FAIL bp_done row%0d got=timeout expected=pulse", r); end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (done_cnt - dbase != 3) begin errors++; $display("FAIL bp_done_count got=%0d expected=3", done_cnt - dbase); end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable got=%0d expected=0", stall_viol); end
    checks++;
    if (occ_viol != 0) begin errors++; $display("FAIL bp_occupancy got=%0d expected=0", occ_viol); end
    while (obs_rd < obs_q.size()) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra_beat got=%h expected=none", obs_q[obs_rd]); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL bp_beat got=%h expected=%h", obs_q[obs_rd], e); end
      end
      obs_rd++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_missing got=%0d expected=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_full_throughput();
    int cyc, run;
    logic [17:0] e;
    out_ready = 1'b1; pass2_go = 1'b1;
    for (int i = 0; i < C_MAX; i++) row_vals[i] = 16'($urandom_range(0, 16'hFFFF));
    drive_row(11'd1024, C_MAX);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || row_max !== exp_max) begin
      errors++; $display("FAIL tp_entry got=%b%b/%h expected=00/%h", out_valid, in_ready, row_max, exp_max);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL tp_latency1 got=%b expected=0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL tp_latency2 got=%b expected=1", out_valid); end
    run = 0;
    while (out_valid && run < 1100) begin run++; @(negedge clk); end
    checks++;
    if (run != C_MAX) begin errors++; $display("FAIL tp_run got=%0d expected=1024", run); end
    cyc = 0;
    while (!done && cyc < 1200) begin @(negedge clk); cyc++; end
    checks++;
    if (!done) begin errors++; $display("FAIL tp_done got=timeout expected=pulse"); end
    @(posedge clk); #1;
    while (obs_rd < obs_q.size()) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL tp_extra_beat got=%h expected=none", obs_q[obs_rd]); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL tp_beat got=%h expected=%h", obs_q[obs_rd], e); end
      end
      obs_rd++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL tp_missing got=%0d expected=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_boundaries();
    int cyc;
    logic [17:0] e;
    out_ready = 1'b1; pass2_go = 1'b1;
    // len 1: straight from IDLE to PASS1
    row_vals[0] = 16'h5555;
    drive_row(11'd1, 1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || row_max !== 16'h5555) begin
      errors++; $display("FAIL len1_entry got=%b%b/%h expected=01/5555", in_ready, busy, row_max);
    end
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (!done) begin errors++; $display("FAIL len1_done got=timeout expected=pulse"); end
    @(posedge clk); #1;
    // len 0 clamps to the full buffer
    for (int i = 0; i < C_MAX; i++) row_vals[i] = 16'($urandom_range(0, 16'hFFFF));
    drive_row(11'd0, C_MAX);
    cyc = 0;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    checks++;
    if (!done) begin errors++; $display("FAIL len0_done got=timeout expected=pulse"); end
    @(posedge clk); #1;
    // -0 followed by +0: +0 is strictly greater
    row_vals[0] = 16'h8000; row_vals[1] = 16'h0000;
    drive_row(11'd2, 2);
    @(negedge clk);
    checks++;
    if (row_max !== 16'h0000 || exp_max !== 16'h0000) begin
      errors++; $display("FAIL negzero_max got=%h expected=0000", row_max);
    end
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (!done) begin errors++; $display("FAIL negzero_done got=timeout expected=pulse"); end
    @(posedge clk); #1;
    while (obs_rd < obs_q.size()) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL bound_extra_beat got=%h expected=none", obs_q[obs_rd]); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL bound_beat got=%h expected=%h", obs_q[obs_rd], e); end
      end
      obs_rd++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bound_missing got=%0d expected=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_wait_reset();
    int cyc, obase;
    logic [17:0] e;
    out_ready = 1'b1; pass2_go = 1'b0;
    for (int i = 0; i < 4; i++) row_vals[i] = 16'($urandom_range(0, 16'h7BFF));
    obase = obs_q.size();
    drive_row(11'd4, 4);
    cyc = 0;
    while ((obs_q.size() - obase) < 4 && cyc < 100) begin @(negedge clk); cyc++; end
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (dut.state_q !== WAIT || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL wait_hold cycle%0d got=%0d/%b/%b expected=%0d/0/0", i, dut.state_q, out_valid, in_ready, WAIT);
      end
      @(posedge clk); #1;
    end
    // pass-1 beats only; the pass-2 expectations are discarded by the reset below
    while (obs_rd < obs_q.size()) begin
      checks++;
      e = exp_q.pop_front();
      if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL wait_pass1_beat got=%h expected=%h", obs_q[obs_rd], e); end
      obs_rd++;
    end
    out_ready = 1'b0; pass2_go = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 20);
    checks++;
    if (out_valid !== 1'b1 || out_pass !== 1'b1 || out_data !== row_vals[0] || out_last !== 1'b0) begin
      errors++; $display("FAIL pass2_start got=%b%b%b/%h expected=110/%h", out_valid, out_pass, out_last, out_data, row_vals[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done, lb_we, out_pass, out_last} !== 7'b1000000) begin
      errors++; $display("FAIL midreset_flags got=%b expected=1000000", {in_ready, out_valid, busy, done, lb_we, out_pass, out_last});
    end
    checks++;
    if (row_max !== 16'hFC00 || lb_raddr !== '0 || lb_waddr !== '0) begin
      errors++; $display("FAIL midreset_regs got=%h/%h/%h expected=fc00/0/0", row_max, lb_raddr, lb_waddr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    obs_rd = obs_q.size();
    out_ready = 1'b1;
    row_vals[0] = 16'hBC00; row_vals[1] = 16'h4400; row_vals[2] = 16'h3800;
    drive_row(11'd3, 3);
    @(negedge clk);
    checks++;
    if (row_max !== 16'h4400) begin errors++; $display("FAIL postreset_max got=%h expected=4400", row_max); end
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (!done) begin errors++; $display("FAIL postreset_done got=timeout expected=pulse"); end
    @(posedge clk); #1;
    while (obs_rd < obs_q.size()) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL postreset_extra_beat got=%h expected=none", obs_q[obs_rd]); end
      else begin
        e = exp_q.pop_front();
        if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL postreset_beat got=%h expected=%h", obs_q[obs_rd], e); end
      end
      obs_rd++;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL postreset_missing got=%0d expected=0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_full_throughput();
    test_boundaries();
    test_wait_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/softmax_row_ctrl.md
Name: softmax_row_ctrl

Overview:
Row sequencer for the softmax datapath. It owns one 16-bit line buffer: it streams one row of fp16 logits into the buffer and tracks the row maximum. It then replays the row twice: pass 1 feeds exp/sum, pass 2 feeds normalize. Replay runs through a credit-controlled 2-entry skid so downstream backpressure never loses a read.

Parameters:
C_MAX, 1024, maximum row length (line buffer depth)
ADDR_W, 10, line buffer address width, $clog2(C_MAX)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_len  in  ADDR_W+1  row length, sampled at first accepted input beat
in_valid  in  1  input logit valid
in_ready  out  1  controller accepts input beat
in_data  in  16  fp16 logit
lb_we  out  1  line buffer write enable
lb_waddr  out  ADDR_W  line buffer write address
lb_wdata  out  16  line buffer write data
lb_raddr  out  ADDR_W  line buffer read address
lb_rdata  in  16  line buffer read data, 1-cycle registered latency
out_valid  out  1  replay beat valid
out_ready  in  1  downstream accepts beat
out_data  out  16  replayed logit
out_pass  out  1  0 = pass 1 (exp/sum), 1 = pass 2 (normalize)
out_last  out  1  final beat of the current pass
row_max  out  16  fp16 max of current row, stable from PASS1 entry until next row starts
pass2_go  in  1  level: downstream reciprocal ready, permits pass 2
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after last pass-2 beat accepted

Behaviour:
- Reset values: state IDLE, in_ready=1, lb_we=0, lb_waddr=0, lb_raddr=0, lb_wdata=0, out_valid=0, out_pass=0, out_last=0, row_max=16'hFC00 (-inf), busy=0, done=0. Skid buffer and in-flight flag are cleared.
- The line buffer is written combinationally from the accepted beat: lb_we = in_valid & in_ready, lb_wdata = in_data, lb_waddr = write counter.
- IDLE: in_ready=1. On the first accepted beat:
  - latch len = cfg_len; 0 or >C_MAX clamps to C_MAX;
  - write address 0; row_max = in_data; go to LOAD, or to PASS1 if len==1.
- LOAD: in_ready=1. Each accepted beat writes the next address and updates row_max. The beat with index len-1 moves to PASS1 on the next cycle. in_ready=0 in all other states.
- fp16 max compare: key = sign ? ~x : (x | 16'h8000), unsigned compare, strictly greater replaces. -0 < +0. NaN receives no special handling.
- PASS1/PASS2 read engine:
  - issue a read at cycle t when rd_ptr<len and (occ + inflight - pop) < 2;
  - lb_rdata is valid at t+1 and is pushed into the skid at the end of t+1, so out_valid is asserted from t+2;
  - with out_ready held high, throughput is 1 beat/cycle;
  - a beat is popped when out_valid & out_ready; out_data, out_pass and out_last are held stable while out_valid & !out_ready.
- out_last=1 on beat index len-1 of each pass.
- End of PASS1: after the pass-1 last beat pops, go to WAIT. WAIT goes to PASS2 on the first cycle pass2_go=1, so a minimum of 1 WAIT cycle. rd_ptr resets to 0 on PASS2 entry.
- End of PASS2: after the last beat pops, go to IDLE and pulse done the same edge. in_ready returns to 1 in the following cycle.
- No overlap of rows; the next row waits for IDLE.
- rst_n low at any time forces reset values immediately. Partial rows are discarded; buffer contents are don't-care.
- len==1: one LOAD beat, then each pass emits a single beat with out_last=1.

Decomposition:
- Package softmax_pkg:
  - FP16_NEG_INF = 16'hFC00;
  - state enum {IDLE, LOAD, PASS1, WAIT, PASS2};
  - function fp16_key().
- Sub-module rd_skid2: 2-entry skid with credit/in-flight tracking. It is reused for both passes.

Test Plan:
- Reset/idle: rst_n low then high -> in_ready=1, out_valid=0, row_max=16'hFC00, busy=0.
- len=4, inputs {3C00,C000,4200,0000}, out_ready=1, pass2_go=1:
  - writes addr 0..3;
  - row_max=4200;
  - pass 1 emits the 4 values with out_last on the 4th;
  - pass 2 emits the same with out_pass=1;
  - done pulses once.
- Backpressure: len=8, out_ready random 50%:
  - order is preserved, no duplicate or dropped beats;
  - out_data is stable while stalled;
  - skid occupancy never exceeds 2.
- Full throughput: len=C_MAX=1024, out_ready=1 -> first out_valid 2 cycles after PASS1 entry, then 1024 consecutive beats.
- Boundaries:
  - cfg_len=1 -> one beat per pass with out_last=1;
  - cfg_len=0 -> 1024 beats per pass;
  - inputs {8000,0000} -> row_max=0000.
- pass2_go held low 10 cycles after pass 1 -> state WAIT, out_valid=0. Raising pass2_go -> pass 2 starts. rst_n pulsed mid-PASS2 -> all outputs return to reset values and the next row loads correctly.
